// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: resets the PLL, qualifies lock, releases sys then cpu reset.
// Define PLLSEQ_FAULT_EN to cap lock attempts at MAX_RETRIES and latch FAULT.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CPU_DELAY      = 256,
    parameter int SOFT_CYCLES    = 64,
    parameter int MAX_RETRIES    = 4
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       cpu_reset,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        SYS_RUN   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                           PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (STABLE_CYCLES > CPU_DELAY) ?
                           STABLE_CYCLES : CPU_DELAY;
    localparam int CW = $clog2((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1;
    localparam int SW = $clog2(SOFT_CYCLES) + 1;

    localparam logic [CW-1:0] T_PLL  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] T_LOCK = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] T_STB  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] T_CPU  = CW'(CPU_DELAY - 1);
    localparam logic [SW-1:0] T_SOFT = SW'(SOFT_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [SW-1:0] soft_cnt;
    logic [SW-1:0] soft_cnt_nxt;
    logic          soft_act;
    logic          soft_act_nxt;
    logic          sync1;
    logic          lk;
    logic          soft_q;
    logic          soft_rise;
    logic          retry_last;

    assign soft_rise = soft_reset & ~soft_q;
    assign state_o   = state;

`ifdef PLLSEQ_FAULT_EN
    logic [2:0] retry;

    assign retry_last = (retry == 3'(MAX_RETRIES - 1));

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            retry <= '0;
            fault <= 1'b0;
        end else begin
            if (state_nxt == RUN)
                retry <= '0;
            else if (state == WAIT_LOCK && !lk && cnt == T_LOCK)
                retry <= retry + 3'd1;
            fault <= (state_nxt == FAULT);
        end
    end
`else
    localparam int unused_max_retries = MAX_RETRIES;

    assign retry_last = 1'b0;
    assign fault      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            PLL_RST: begin
                if (cnt == T_PLL) state_nxt = WAIT_LOCK;
                else cnt_nxt = cnt + CW'(1);
            end
            WAIT_LOCK: begin
                if (lk) state_nxt = STABLE;
                else if (cnt == T_LOCK)
                    state_nxt = retry_last ? FAULT : PLL_RST;
                else cnt_nxt = cnt + CW'(1);
            end
            STABLE: begin
                if (!lk) state_nxt = WAIT_LOCK;
                else if (cnt == T_STB) state_nxt = SYS_RUN;
                else cnt_nxt = cnt + CW'(1);
            end
            SYS_RUN: begin
                if (!lk) state_nxt = PLL_RST;
                else if (cnt == T_CPU) state_nxt = RUN;
                else cnt_nxt = cnt + CW'(1);
            end
            RUN: begin
                if (!lk) state_nxt = PLL_RST;
            end
            FAULT: state_nxt = FAULT;
            default: state_nxt = PLL_RST;
        endcase

        // Soft pulse lives only while RUN persists; lock loss kills it.
        soft_act_nxt = 1'b0;
        soft_cnt_nxt = '0;
        if (state == RUN && state_nxt == RUN) begin
            if (soft_rise) begin
                soft_act_nxt = 1'b1;
            end else if (soft_act && soft_cnt != T_SOFT) begin
                soft_act_nxt = 1'b1;
                soft_cnt_nxt = soft_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            lk        <= 1'b0;
            soft_q    <= 1'b0;
            state     <= PLL_RST;
            cnt       <= '0;
            soft_cnt  <= '0;
            soft_act  <= 1'b0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            cpu_reset <= 1'b1;
            ready     <= 1'b0;
        end else begin
            sync1     <= pll_locked;
            lk        <= sync1;
            soft_q    <= soft_reset;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            soft_cnt  <= soft_cnt_nxt;
            soft_act  <= soft_act_nxt;
            pll_rst   <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
            sys_reset <= !((state_nxt == SYS_RUN) || (state_nxt == RUN));
            cpu_reset <= (state_nxt != RUN) || soft_act_nxt;
            ready     <= (state_nxt == RUN);
        end
    end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Downstream neighbour of the system PLL wrapper, clocked from the free-running 50 MHz reference clock.
- Drives the PLL's active-high reset and consumes its asynchronous `locked` flag.
- Issues ordered reset releases to the core: system reset first, CPU reset later.
- Re-sequences automatically on loss of lock; also services soft-reset requests from the OSD.

Parameters:
- PLL_RST_CYCLES, 16, clk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before retrying (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, contiguous cycles locked must stay high before sys_reset release.
- CPU_DELAY, 256, cycles between sys_reset release and cpu_reset release.
- SOFT_CYCLES, 64, cpu_reset pulse length for a soft reset.
- MAX_RETRIES, 4, failed lock attempts before FAULT (used only with PLLSEQ_FAULT_EN).

Ports:
- clk_50  in  1  free-running 50 MHz reference clock; all logic runs on it.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked flag, asynchronous to clk_50; 2-flop synchronised internally.
- soft_reset  in  1  synchronous level request; edge-detected internally.
- pll_rst  out  1  active-high reset to the PLL.
- sys_reset  out  1  active-high core reset.
- cpu_reset  out  1  active-high CPU reset.
- ready  out  1  high only in RUN.
- fault  out  1  lock never achieved (feature-dependent).
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - pll_rst=1, sys_reset=1, cpu_reset=1, ready=0, fault=0.
  - state=PLL_RST, all counters 0, synchroniser flops 0.
- All outputs are registered. Consumers resynchronise sys_reset and cpu_reset into their own PLL clock domains.
- Synchronised lock (lk) lags pll_locked by 2 clocks.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, SYS_RUN=3, RUN=4, FAULT=5.
- PLL_RST:
  - pll_rst=1, sys_reset=1, cpu_reset=1.
  - Count PLL_RST_CYCLES, then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - pll_rst=0.
  - lk=1 -> STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 -> retry count +1, then PLL_RST.
- STABLE:
  - Any lk=0 -> WAIT_LOCK; the timeout counter restarts from 0.
  - Counter reaches STABLE_CYCLES-1 with lk=1 -> SYS_RUN, and sys_reset drops on the same transition edge.
- SYS_RUN:
  - sys_reset=0, cpu_reset=1.
  - After CPU_DELAY cycles -> RUN: cpu_reset=0, ready=1, retry count cleared.
- RUN: stays here while lk=1.
- Loss of lock: lk=0 in SYS_RUN or RUN -> PLL_RST on the next edge, re-asserting all resets and dropping ready that same edge.
- Soft reset:
  - A soft_reset rising edge in RUN asserts cpu_reset for exactly SOFT_CYCLES cycles; ready stays 1 and state stays RUN.
  - An edge during an active pulse restarts the pulse count.
  - Edges outside RUN are ignored.
  - Loss of lock overrides a soft pulse.
- Simultaneous events: loss of lock and a soft edge on the same cycle -> loss of lock wins.
- Widths:
  - Each counter is $clog2(max parameter it compares against)+1 bits wide and never wraps.
  - The counter saturates at its terminal count until the state exits.
- Mid-operation rst_n assertion forces the reset values immediately, asynchronously. Deassertion is followed by a full sequence from PLL_RST.

Optional Feature:
- Macro: PLLSEQ_FAULT_EN.
- With the macro defined:
  - A 3-bit retry counter is implemented.
  - A timeout that makes retries reach MAX_RETRIES -> FAULT, with fault=1, pll_rst=1, sys_reset=1, cpu_reset=1.
  - FAULT is terminal until rst_n.
- Without the macro: no retry counter is implemented, retries are unlimited, fault is tied 0, and state 5 is unreachable.

Test Plan:
- Lock behaviour:
  - Release rst_n; pll_locked rises 100 cycles after pll_rst falls and stays high -> pll_rst high for 16 cycles.
  - sys_reset falls 2+1024 cycles after pll_locked rises.
  - cpu_reset falls 256 cycles later; ready=1 and state_o=4.
- Lock glitch: pll_locked drops for 3 cycles midway through STABLE -> state returns to WAIT_LOCK (1) and the full 1024-cycle stability count restarts; sys_reset stays 1 throughout.
- Lock loss: in RUN, drop pll_locked -> within 3 cycles pll_rst, sys_reset, cpu_reset are 1 and ready=0; the sequence then repeats to RUN.
- Soft reset: in RUN, pulse soft_reset high for 5 cycles -> cpu_reset high for exactly 64 cycles, sys_reset stays 0, ready stays 1.
- Mid-sequence reset: assert rst_n low during SYS_RUN -> outputs return to reset values the same cycle without a clock edge.
- Fault: with PLLSEQ_FAULT_EN, hold pll_locked=0 -> after 4 timeouts (4×(16+50000) cycles) state_o=5, fault=1, pll_rst=1; without the macro, pll_rst keeps pulsing every 50016 cycles and fault stays 0.
